mem_sram: RTL and testbench
===========================

Name: mem_sram

Overview:
- Downstream memory stage for the data-bus-to-memory bridge.
- Consumes the bridge's memory-side request (addr/wdata/size/ren/wen) and returns rdata/ready/fault.
- Byte-addressable on-chip SRAM with programmable wait states, sub-word read/write lanes, and optional alignment/range fault detection.
- Sits behind the bridge as the program/data memory of the SoC.

Parameters:
- DEPTH_WORDS, 4096, number of 32-bit words in the array (power of two).
- BASE_ADDR, 32'h0000_0000, byte address mapped to word 0.
- WAIT_STATES, 1, extra cycles between request capture and ready (0..15).

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- addr  input  32  byte address of request
- wdata  input  32  write data, right-justified for sub-word sizes
- size  input  2  00 byte, 01 halfword, 10 word, 11 reserved
- ren  input  1  read request
- wen  input  1  write request; ren=1 and wen=1 together is a write
- rdata  output  32  read data, right-justified, zero-extended
- ready  output  1  one-cycle pulse: access complete
- fault  output  1  valid only while ready=1; access was rejected

Behaviour:
- Reset: rst, synchronous, active-high; clock clk. State=IDLE, ready=0, fault=0, rdata=0, wait counter=0. Array contents are not cleared.
- Request valid = ren|wen. Type = write if wen=1, else read.
- States:
  - IDLE: on valid, capture addr/wdata/size/type and load the counter with WAIT_STATES, then go to BUSY. Otherwise stay in IDLE.
  - BUSY: while the counter is nonzero, decrement it; ready=0, inputs ignored. When the counter is 0, assert ready=1 for this cycle and complete the access.
  - Completion (the ready cycle): sample the inputs. If valid, capture the new request and stay in BUSY (back-to-back; next ready after WAIT_STATES+1 cycles). Else go to IDLE.
- Latency: request seen in IDLE at cycle N -> ready at cycle N+1+WAIT_STATES. Back-to-back throughput: one access per WAIT_STATES+1 cycles.
- Inputs are don't-care between capture and the ready cycle. Only the captured copy is used.
- Word index = (addr-BASE_ADDR)>>2, modulo DEPTH_WORDS.
- Write lanes:
  - Byte: wdata[7:0] into lane addr[1:0].
  - Half: wdata[15:0] into lanes {addr[1],0} and {addr[1],1}.
  - Word: all four lanes.
  - Other lanes are unchanged. The write commits at the ready-cycle clock edge.
- Read: the selected lanes are shifted to bit 0 and zero-extended. rdata is valid in the ready cycle and held until the next ready. For writes, rdata is not updated.
- A synchronous array read is permitted, but rdata must be valid in the ready cycle even when WAIT_STATES=0. Read-after-write to the same address in consecutive accesses returns the new data.
- fault=0 whenever ready=0.
- Reset asserted in BUSY aborts the access: no write commit, no ready, state goes to IDLE.

Optional Feature:
- Macro: MEM_SRAM_FAULT_EN.
- Defined: fault=1 with ready for any of:
  - misaligned halfword (addr[0]=1);
  - misaligned word (addr[1:0]!=0);
  - size=11;
  - addr outside [BASE_ADDR, BASE_ADDR+4*DEPTH_WORDS).
  A faulting write modifies nothing. A faulting read returns rdata=0. Latency is unchanged.
- Undefined: fault tied 0. size=11 is treated as word. Misaligned accesses use addr[1:0] lanes as specified, with the word access ignoring addr[1:0]. Out-of-range addresses wrap modulo the array size.

Test Plan:
- WAIT_STATES=1: write word 0xDEADBEEF to 0x10 (ren=1,wen=1,size=10) -> ready 2 cycles after request. Then read 0x10 -> rdata=0xDEADBEEF with ready, fault=0.
- Byte write 0xAA to 0x13 over 0x11223344 at 0x10 -> word read gives 0xAA223344. Byte read 0x13 gives 0x000000AA. Half read 0x12 gives 0x0000AA22.
- Back-to-back: new read presented in the ready cycle of the previous write, WAIT_STATES=0 -> ready on consecutive cycles, second returns the just-written data.
- MEM_SRAM_FAULT_EN: word write to 0x02 -> ready with fault=1, memory at 0x00 unchanged. Read at BASE_ADDR+4*DEPTH_WORDS -> fault=1, rdata=0.
- WAIT_STATES=3: rst pulsed 2 cycles after a write capture -> no ready, target word unchanged. Next request completes normally 4 cycles after capture.
- Idle with ren=0, wen=0 for 10 cycles (wdata/addr toggling) -> ready stays 0, memory unchanged.

Source files
------------

// File: rtl/mem_sram.sv
// mem_sram: byte-addressable on-chip SRAM with wait states and sub-word lanes.
// Define MEM_SRAM_FAULT_EN to reject misaligned, reserved-size and out-of-range accesses.
module mem_sram #(
  parameter int          DEPTH_WORDS = 4096,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [1:0]  size,
  input  logic        ren,
  input  logic        wen,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        fault
);

  localparam int         AW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] WS = 4'(WAIT_STATES);

  typedef enum logic {IDLE, BUSY} state_e;

  state_e      state_q;
  logic [3:0]  cnt_q;
  logic        ready_q;
  logic [31:0] rdata_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [1:0]  size_q;
  logic        wr_q;

  logic [31:0] mem [DEPTH_WORDS];

  logic          valid;
  logic          take;
  logic [31:0]   off;
  logic [AW-1:0] idx;
  logic [1:0]    lane;
  logic          bad;
  logic [3:0]    be;
  logic [31:0]   wlane;
  logic [31:0]   word;
  logic [31:0]   rd_now;

  assign valid = ren | wen;
  assign take  = valid & ((state_q == IDLE) | ready_q);
  assign off   = addr_q - BASE_ADDR;
  assign idx   = off[AW+1:2];
  assign lane  = addr_q[1:0];

`ifdef MEM_SRAM_FAULT_EN
  localparam logic [32:0] SPAN = 33'(DEPTH_WORDS) << 2;

  assign bad = (size_q == 2'b11)
             | ((size_q == 2'b01) & lane[0])
             | ((size_q == 2'b10) & (lane != 2'b00))
             | ({1'b0, off} >= SPAN);
`else
  logic unused_off;

  assign bad        = 1'b0;
  assign unused_off = ^off;
`endif

  // Only the captured request drives the array; live inputs are ignored while busy.
  always_comb begin
    be     = 4'b1111;
    wlane  = wdata_q;
    word   = mem[idx];
    rd_now = word;
    unique case (1'b1)
      size_q == 2'b00: begin
        be     = 4'b0001 << lane;
        wlane  = {4{wdata_q[7:0]}};
        rd_now = {24'h0, word[8*lane +: 8]};
      end
      size_q == 2'b01: begin
        be     = lane[1] ? 4'b1100 : 4'b0011;
        wlane  = {2{wdata_q[15:0]}};
        rd_now = {16'h0, lane[1] ? word[31:16] : word[15:0]};
      end
      default: ;
    endcase
    if (bad) rd_now = '0;
  end

  always_ff @(posedge clk) begin
    if (take) begin
      addr_q  <= addr;
      wdata_q <= wdata;
      size_q  <= size;
      wr_q    <= wen;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && ready_q && wr_q && !bad) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= wlane[8*i +: 8];
      end
    end
  end

  // ready_q is high exactly when BUSY with the counter at zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ready_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      ready_q <= 1'b0;
      if (ready_q && !wr_q) rdata_q <= rd_now;
      if (take) begin
        state_q <= BUSY;
        cnt_q   <= WS;
        ready_q <= (WS == 4'd0);
      end else if (state_q == BUSY && cnt_q != 4'd0) begin
        cnt_q   <= cnt_q - 4'd1;
        ready_q <= (cnt_q == 4'd1);
      end else begin
        state_q <= IDLE;
      end
    end
  end

  assign ready = ready_q;
  assign fault = ready_q & bad;
  assign rdata = (ready_q & ~wr_q) ? rd_now : rdata_q;

endmodule

// File: tb/tb_mem_sram.sv
// tb_mem_sram: three mem_sram instances (0, 1 and 3 wait states) checked
// every cycle against a transaction-level memory model.
module tb_mem_sram;

  localparam int          DEPTH = 64;
  localparam logic [31:0] BASE  = 32'h0000_1000;
`ifdef MEM_SRAM_FAULT_EN
  localparam bit FEN = 1'b1;
`else
  localparam bit FEN = 1'b0;
`endif

  typedef struct {
    int          d;
    logic [31:0] a;
    logic [31:0] wd;
    logic [1:0]  sz;
    bit          wr;
    longint      due;
  } req_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] addr_s  [3];
  logic [31:0] wdata_s [3];
  logic [1:0]  size_s  [3];
  logic        ren_s   [3];
  logic        wen_s   [3];
  logic [31:0] rdata_s [3];
  logic        ready_s [3];
  logic        fault_s [3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    mem_sram #(
      .DEPTH_WORDS(DEPTH),
      .BASE_ADDR  (BASE),
      .WAIT_STATES(g == 0 ? 0 : (g == 1 ? 1 : 3))
    ) u_dut (
      .clk  (clk),
      .rst  (rst),
      .addr (addr_s[g]),
      .wdata(wdata_s[g]),
      .size (size_s[g]),
      .ren  (ren_s[g]),
      .wen  (wen_s[g]),
      .rdata(rdata_s[g]),
      .ready(ready_s[g]),
      .fault(fault_s[g])
    );
  end

  always #5 clk = ~clk;

  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] mdl [3][DEPTH];
  logic [31:0] hold [3];
  logic [31:0] obs_rd [3];
  logic        obs_flt [3];
  longint      obs_cyc [3];
  req_t        q[$];
  int          checks = 0;
  int          errors = 0;

  function automatic int ws_of(int d);
    return d == 0 ? 0 : (d == 1 ? 1 : 3);
  endfunction

  function automatic bit m_fault(logic [31:0] a, logic [1:0] sz);
    logic [31:0] off;
    off = a - BASE;
    if (!FEN) return 1'b0;
    if (sz == 2'd3) return 1'b1;
    if (sz == 2'd1 && (a % 2) != 0) return 1'b1;
    if (sz == 2'd2 && (a % 4) != 0) return 1'b1;
    return off >= DEPTH * 4;
  endfunction

  function automatic int m_idx(logic [31:0] a);
    return int'(((a - BASE) / 4) % DEPTH);
  endfunction

  function automatic logic [31:0] m_read(logic [31:0] w, logic [1:0] sz, int ln);
    if (sz == 2'd0) return (w >> (8 * ln)) & 32'hFF;
    if (sz == 2'd1) return (w >> (16 * (ln / 2))) & 32'hFFFF;
    return w;
  endfunction

  function automatic logic [31:0] m_write(logic [31:0] w, logic [31:0] wd,
                                          logic [1:0] sz, int ln);
    logic [31:0] r;
    r = w;
    for (int i = 0; i < 4; i++) begin
      if (sz == 2'd0 && i == ln) r[8*i +: 8] = wd[7:0];
      if (sz == 2'd1 && i / 2 == ln / 2) r[8*i +: 8] = wd[8*(i%2) +: 8];
      if (sz >= 2'd2) r[8*i +: 8] = wd[8*i +: 8];
    end
    return r;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic check_unit(int d);
    req_t        r;
    bit          f;
    int          wi;
    int          ln;
    logic [31:0] w;
    logic [31:0] e;
    if (ready_s[d] !== 1'b1) begin
      chk($sformatf("fault_idle_d%0d", d), {31'b0, fault_s[d]}, 32'd0);
      chk($sformatf("rdata_hold_d%0d", d), rdata_s[d], hold[d]);
      if (q.size() > 0 && q[0].d == d && q[0].due <= cyc) begin
        r = q.pop_front();
        checks++;
        errors++;
        $display("FAIL missing_ready_d%0d: got 0 want 1 at cycle %0d", d, r.due);
      end
    end else if (!(q.size() > 0 && q[0].d == d)) begin
      checks++;
      errors++;
      $display("FAIL spurious_ready_d%0d: got 1 want 0 at cycle %0d", d, cyc);
    end else begin
      r  = q.pop_front();
      f  = m_fault(r.a, r.sz);
      wi = m_idx(r.a);
      ln = int'(r.a % 4);
      w  = mdl[d][wi];
      if (r.wr) begin
        if (!f) mdl[d][wi] = m_write(w, r.wd, r.sz, ln);
        e = hold[d];
      end else begin
        e = f ? 32'd0 : m_read(w, r.sz, ln);
        hold[d] = e;
      end
      chk($sformatf("latency_d%0d", d), 32'(cyc), 32'(r.due));
      chk($sformatf("rdata_d%0d", d), rdata_s[d], e);
      chk($sformatf("fault_d%0d", d), {31'b0, fault_s[d]}, {31'b0, f});
      obs_rd[d]  = rdata_s[d];
      obs_flt[d] = fault_s[d];
      obs_cyc[d] = cyc;
    end
  endtask

  always @(negedge clk) begin
    if (rst === 1'b0) begin
      for (int d = 0; d < 3; d++) check_unit(d);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic garbage(int d, bit vld);
    addr_s[d]  = $urandom;
    wdata_s[d] = $urandom;
    size_s[d]  = 2'($urandom);
    ren_s[d]   = vld & 1'($urandom);
    wen_s[d]   = vld & 1'($urandom);
  endtask

  task automatic drive(int d, logic [31:0] a, logic [31:0] wd, logic [1:0] sz,
                       bit r, bit w, output longint due);
    req_t e;
    addr_s[d]  = a;
    wdata_s[d] = wd;
    size_s[d]  = sz;
    ren_s[d]   = r;
    wen_s[d]   = w;
    due   = cyc + 1 + ws_of(d);
    e.d   = d;
    e.a   = a;
    e.wd  = wd;
    e.sz  = sz;
    e.wr  = w;
    e.due = due;
    q.push_back(e);
  endtask

  // Returns in the ready cycle with inputs idle, so another call is back-to-back.
  task automatic access(int d, logic [31:0] a, logic [31:0] wd, logic [1:0] sz,
                        bit r, bit w);
    longint due;
    drive(d, a, wd, sz, r, w, due);
    while (cyc < due) begin
      step();
      if (cyc < due) garbage(d, 1'b1);
    end
    garbage(d, 1'b0);
  endtask

  task automatic do_reset(int n);
    rst = 1'b1;
    q.delete();
    repeat (n) step();
    rst = 1'b0;
    for (int d = 0; d < 3; d++) hold[d] = '0;
  endtask

  initial begin
    #1000000;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1);
  end

  initial begin
    longint t0;
    longint due;
    int     op;
    for (int d = 0; d < 3; d++) begin
      addr_s[d]  = '0;
      wdata_s[d] = '0;
      size_s[d]  = '0;
      ren_s[d]   = 1'b0;
      wen_s[d]   = 1'b0;
      hold[d]    = '0;
    end
    step();
    do_reset(3);
    step();
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("rst_ready_d%0d", d), {31'b0, ready_s[d]}, 32'd0);
      chk($sformatf("rst_fault_d%0d", d), {31'b0, fault_s[d]}, 32'd0);
      chk($sformatf("rst_rdata_d%0d", d), rdata_s[d], 32'd0);
    end

    for (int d = 0; d < 3; d++) begin
      for (int i = 0; i < DEPTH; i++) begin
        access(d, BASE + 32'(4 * i), $urandom, 2'd2, 1'($urandom), 1'b1);
      end
    end

    t0 = cyc;
    access(1, BASE + 32'h10, 32'hDEAD_BEEF, 2'd2, 1'b1, 1'b1);
    step();
    chk("ws1_write_latency", 32'(obs_cyc[1] - t0), 32'd2);
    access(1, BASE + 32'h10, $urandom, 2'd2, 1'b1, 1'b0);
    step();
    chk("ws1_read_word", obs_rd[1], 32'hDEAD_BEEF);
    chk("ws1_read_fault", {31'b0, obs_flt[1]}, 32'd0);

    access(1, BASE + 32'h10, 32'h1122_3344, 2'd2, 1'b0, 1'b1);
    access(1, BASE + 32'h13, 32'h5555_77AA, 2'd0, 1'b0, 1'b1);
    access(1, BASE + 32'h10, 32'h0, 2'd2, 1'b1, 1'b0);
    step();
    chk("byte_merge_word", obs_rd[1], 32'hAA22_3344);
    access(1, BASE + 32'h13, 32'h0, 2'd0, 1'b1, 1'b0);
    step();
    chk("byte_read", obs_rd[1], 32'h0000_00AA);
    access(1, BASE + 32'h12, 32'h0, 2'd1, 1'b1, 1'b0);
    step();
    chk("half_read", obs_rd[1], 32'h0000_AA22);

    t0 = cyc;
    access(0, BASE + 32'h20, 32'hCAFE_F00D, 2'd2, 1'b0, 1'b1);
    access(0, BASE + 32'h20, 32'h0, 2'd2, 1'b1, 1'b0);
    step();
    chk("b2b_second_ready", 32'(obs_cyc[0] - t0), 32'd2);
    chk("b2b_raw_data", obs_rd[0], 32'hCAFE_F00D);

`ifdef MEM_SRAM_FAULT_EN
    access(1, BASE, 32'h0102_0304, 2'd2, 1'b0, 1'b1);
    access(1, BASE + 32'h2, 32'h5555_5555, 2'd2, 1'b0, 1'b1);
    step();
    chk("misaligned_fault", {31'b0, obs_flt[1]}, 32'd1);
    access(1, BASE, 32'h0, 2'd2, 1'b1, 1'b0);
    step();
    chk("misaligned_nowrite", obs_rd[1], 32'h0102_0304);
    access(1, BASE + 32'(4 * DEPTH), 32'h0, 2'd2, 1'b1, 1'b0);
    step();
    chk("range_fault", {31'b0, obs_flt[1]}, 32'd1);
    chk("range_rdata", obs_rd[1], 32'd0);
`else
    access(1, BASE + 32'(4 * DEPTH + 4), 32'h0BAD_F00D, 2'd2, 1'b0, 1'b1);
    access(1, BASE + 32'h4, 32'h0, 2'd2, 1'b1, 1'b0);
    step();
    chk("wrap_write", obs_rd[1], 32'h0BAD_F00D);
    access(1, BASE + 32'h8, 32'hA5A5_5A5A, 2'd3, 1'b0, 1'b1);
    access(1, BASE + 32'h8, 32'h0, 2'd2, 1'b1, 1'b0);
    step();
    chk("size3_as_word", obs_rd[1], 32'hA5A5_5A5A);
`endif

    access(2, BASE + 32'h30, 32'h1234_5678, 2'd2, 1'b0, 1'b1);
    drive(2, BASE + 32'h30, 32'hFFFF_FFFF, 2'd2, 1'b0, 1'b1, due);
    step();
    garbage(2, 1'b0);
    step();
    do_reset(2);
    t0 = cyc;
    access(2, BASE + 32'h30, 32'h0, 2'd2, 1'b1, 1'b0);
    step();
    chk("after_abort_latency", 32'(obs_cyc[2] - t0), 32'd4);
    chk("abort_no_write", obs_rd[2], 32'h1234_5678);

    repeat (10) begin
      step();
      for (int d = 0; d < 3; d++) garbage(d, 1'b0);
    end
    access(2, BASE + 32'h30, 32'h0, 2'd2, 1'b1, 1'b0);
    step();
    chk("idle_no_change", obs_rd[2], 32'h1234_5678);

    for (int d = 0; d < 3; d++) begin
      for (int n = 0; n < 150; n++) begin
        repeat ($urandom % 3) begin
          step();
          garbage(d, 1'b0);
        end
        op = int'($urandom % 3);
        access(d, BASE - 32'd8 + ($urandom % (4 * DEPTH + 16)), $urandom,
               2'($urandom), op != 1, op != 0);
      end
    end

    repeat (4) step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
